// File: rtl/i2s_rx_sched_pkg.sv
// Shared types and defaults for the I2S DSP receive transfer scheduler.
//   sched_state_e : scheduler FSM states
//   fifo_entry_t  : one buffered word with its channel tag
package i2s_rx_sched_pkg;

  localparam int unsigned FIFO_DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRun,
    StDrain,
    StDone
  } sched_state_e;

  typedef struct packed {
    logic        ch;
    logic [31:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/i2s_rx_sched_fifo.sv
// Synchronous FIFO of tagged 32-bit words for the receive scheduler.
// The head entry is read straight from the storage registers, so a word pushed at
// cycle N is visible at N+1 (no fall-through). A push into a full FIFO succeeds
// when a pop happens in the same cycle.
//   sck_i/rst_i : clock, asynchronous active-high reset
//   push_i/data_i : write side; full_o reports no free slot
//   pop_i/data_o  : read side; empty_o reports no entry, data_o is the head
module i2s_rx_sched_fifo
  import i2s_rx_sched_pkg::*;
#(
  parameter int unsigned Depth = FIFO_DEPTH_DEF
) (
  input  logic        sck_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  fifo_entry_t data_i,
  input  logic        pop_i,
  output fifo_entry_t data_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam logic [AW:0] FullCnt = (AW + 1)'(Depth);

  fifo_entry_t       mem_q [Depth];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              do_push, do_pop;

  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_rx_dsp_sched.sv
// Transfer scheduler for the I2S DSP receive channel (sck_i domain).
// Arms the channel, counts accepted words, buffers them with a channel tag toward
// the uDMA RX stream, drains the buffer and signals the end with a done pulse.
// Optional watchdog: define I2S_RX_SCHED_TIMEOUT_EN to build the idle-cycle
// timeout; otherwise timeout_o is tied low and cfg_timeout_i is ignored.
//   cfg_*           : start/stop pulses and live transfer configuration
//   chan_*          : channel enable and word handshake from the receive channel
//   rx_*            : tagged word stream toward uDMA
//   busy_o/done_o   : transfer status, done_o is a one-cycle pulse
//   overflow_o/timeout_o : sticky error flags, cleared on the next start
//   word_count_o    : words accepted in the current transfer
module i2s_rx_dsp_sched
  import i2s_rx_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned TMO_W      = 12
) (
  input  logic             sck_i,
  input  logic             rst_i,
  input  logic             cfg_start_i,
  input  logic             cfg_stop_i,
  input  logic [CNT_W-1:0] cfg_num_words_i,
  input  logic             cfg_2ch_i,
  input  logic [TMO_W-1:0] cfg_timeout_i,
  output logic             chan_en_o,
  input  logic [31:0]      chan_data_i,
  input  logic             chan_valid_i,
  output logic             chan_ready_o,
  output logic [31:0]      rx_data_o,
  output logic             rx_ch_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] word_count_o
);

  sched_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             tag_q, tag_d;
  logic             init_q;
  logic             active, accept, last_word;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  fifo_entry_t      push_entry, head_entry;

  assign active = (state_q == StArm) || (state_q == StRun);

  // init_q keeps chan_ready_o low while reset is applied. A full FIFO still takes
  // a word when the head is popped in the same cycle.
  assign chan_ready_o = init_q & (~fifo_full | rx_ready_i);
  assign accept       = chan_valid_i & chan_ready_o;
  assign rx_valid_o   = ~fifo_empty;
  assign fifo_pop     = rx_valid_o & rx_ready_i;

  assign last_word = (cfg_num_words_i != '0) &&
                     (((CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(1)) == (CNT_W + 1)'(cfg_num_words_i));

  assign push_entry.ch   = tag_q & cfg_2ch_i;
  assign push_entry.data = chan_data_i;

  assign chan_en_o    = active;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign overflow_o   = ovf_q;
  assign word_count_o = cnt_q;
  assign rx_data_o    = head_entry.data;
  assign rx_ch_o      = head_entry.ch;

`ifdef I2S_RX_SCHED_TIMEOUT_EN
  logic             tmo_q, tmo_d;
  logic [TMO_W-1:0] idle_q, idle_d;

  assign timeout_o = tmo_q;
`else
  logic unused_tmo;

  assign unused_tmo = ^cfg_timeout_i;
  assign timeout_o  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    tag_d     = tag_q;
    fifo_push = 1'b0;
`ifdef I2S_RX_SCHED_TIMEOUT_EN
    tmo_d     = tmo_q;
    idle_d    = idle_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cfg_start_i && !cfg_stop_i) begin
          state_d = StArm;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          tag_d   = 1'b0;
`ifdef I2S_RX_SCHED_TIMEOUT_EN
          tmo_d   = 1'b0;
          idle_d  = '0;
`endif
        end
      end
      StArm, StRun: begin
        if (accept) begin
          fifo_push = 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cfg_2ch_i) begin
            tag_d = ~tag_q;
          end
          state_d = StRun;
        end else if (chan_valid_i) begin
          // Dropped word: not counted, tag not toggled.
          ovf_d = 1'b1;
        end
`ifdef I2S_RX_SCHED_TIMEOUT_EN
        if (accept) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + 1'b1;
          if ((cfg_timeout_i != '0) && ((idle_q + 1'b1) == cfg_timeout_i)) begin
            tmo_d   = 1'b1;
            state_d = StDrain;
          end
        end
`endif
        // A stop coinciding with an accepted word keeps the word, then drains.
        if (cfg_stop_i || (accept && last_word)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      tag_q   <= 1'b0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      tag_q   <= tag_d;
      init_q  <= 1'b1;
    end
  end

`ifdef I2S_RX_SCHED_TIMEOUT_EN
  always_ff @(posedge sck_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q  <= 1'b0;
      idle_q <= '0;
    end else begin
      tmo_q  <= tmo_d;
      idle_q <= idle_d;
    end
  end
`endif

  i2s_rx_sched_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .sck_i   (sck_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
